vgm_wb_master_protocol_monitor: RTL and testbench

Synthesizable, parametrised Wishbone classic-cycle master protocol monitor. It sits passively on a master's bus and tracks each request from strobe to termination. It checks address and control stability, strobe retention, termination legality and a response timeout. Violations are reported as sticky flags, a one-cycle pulse and saturating counters, so the monitor works in silicon and in simulation.

---
 rtl/vgm_wb_mon_pkg.sv | 26 ++
 rtl/vgm_wb_mon_sat_counter.sv | 36 +++
 rtl/vgm_wb_master_protocol_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_vgm_wb_master_protocol_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgm_wb_mon_pkg.sv
// Shared types and constants for the Wishbone master protocol monitor.
//   mon_state_e  : request tracking state (IDLE, WAIT, TOUT)
//   NUM_CHECKS   : number of violation flags
//   *_IDX        : bit position of each flag in err_flags_o
//   multi_term() : true when more than one termination is asserted
package vgm_wb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TOUT = 2'd2
  } mon_state_e;

  localparam int NUM_CHECKS     = 6;
  localparam int HOLD_IDX       = 0;
  localparam int STB_DROP_IDX   = 1;
  localparam int TIMEOUT_IDX    = 2;
  localparam int MULTI_TERM_IDX = 3;
  localparam int TERM_IDLE_IDX  = 4;
  localparam int STB_NO_CYC_IDX = 5;

  function automatic logic multi_term(input logic ack, input logic err, input logic rty);
    return (ack & err) | (ack & rty) | (err & rty);
  endfunction

endpackage

// File: rtl/vgm_wb_mon_sat_counter.sv
// Saturating up-counter used for the transaction and error counts.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   inc      : add one (holds at all-ones)
//   clr      : synchronous clear to zero
//   load_one : synchronous load of 1, wins over clr (event coincides with a clear)
//   count    : current value
module vgm_wb_mon_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             load_one,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load_one) begin
      count_reg <= WIDTH'(1);
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vgm_wb_master_protocol_monitor.sv
// Passive Wishbone classic-cycle master protocol monitor.
// Tracks each request from strobe to termination and reports address/control
// stability, strobe retention, termination legality and response timeout.
// Optional build macro: VGM_WB_MON_ASSERT_EN adds one SVA assertion per flag.
// Ports:
//   CLK_I, RST_N_I        : clock (rising edge), asynchronous active-low reset
//   CYC_O..SEL_O          : observed master outputs
//   ACK_I, ERR_I, RTY_I   : observed slave terminations
//   clr_i                 : synchronous clear of flags and counters
//   busy_o                : request pending
//   err_flags_o           : sticky violation flags (see vgm_wb_mon_pkg indices)
//   err_pulse_o           : one-cycle pulse after any violation cycle
//   txn_cnt_o, err_cnt_o  : saturating completion / violation-cycle counters
module vgm_wb_master_protocol_monitor
  import vgm_wb_mon_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  localparam int SEL_W  = DAT_W / 8,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_N_I,
  input  logic                  CYC_O,
  input  logic                  STB_O,
  input  logic                  WE_O,
  input  logic [ADR_W-1:0]      ADR_O,
  input  logic [DAT_W-1:0]      DAT_O,
  input  logic [SEL_W-1:0]      SEL_O,
  input  logic                  ACK_I,
  input  logic                  ERR_I,
  input  logic                  RTY_I,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic [NUM_CHECKS-1:0] err_flags_o,
  output logic                  err_pulse_o,
  output logic [CNT_W-1:0]      txn_cnt_o,
  output logic [CNT_W-1:0]      err_cnt_o
);

  // Timer value in the last WAIT cycle before the timeout fires.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  mon_state_e            state_reg, state_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic [ADR_W-1:0]      adr_reg;
  logic [DAT_W-1:0]      dat_reg;
  logic [SEL_W-1:0]      sel_reg;
  logic                  we_reg;
  logic [NUM_CHECKS-1:0] flags_reg;
  logic                  pulse_reg;

  logic                  req;
  logic                  term;
  logic                  hold_diff;
  logic                  capture_en;
  logic                  complete;
  logic                  any_viol;
  logic [NUM_CHECKS-1:0] viol;

  assign req  = CYC_O & STB_O;
  assign term = ACK_I | ERR_I | RTY_I;

  // Write data only has to stay stable on writes.
  assign hold_diff = (ADR_O != adr_reg) | (WE_O != we_reg) | (SEL_O != sel_reg) |
                     (we_reg & (DAT_O != dat_reg));

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    capture_en = 1'b0;
    complete   = 1'b0;
    viol       = '0;

    // State-independent checks.
    viol[STB_NO_CYC_IDX] = STB_O & ~CYC_O;
    viol[MULTI_TERM_IDX] = multi_term(ACK_I, ERR_I, RTY_I);
    viol[TERM_IDLE_IDX]  = term & ~req;

    unique case (state_reg)
      IDLE: begin
        if (req) begin
          if (term) begin
            complete = 1'b1;
          end else begin
            capture_en = 1'b1;
            timer_next = TMR_W'(1);
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        // Stability is judged before the termination decision, so a change on
        // the terminating cycle itself is still caught.
        viol[HOLD_IDX] = req & hold_diff;
        if (req && term) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (!req) begin
          viol[STB_DROP_IDX] = ~term;
          state_next         = IDLE;
        end else if (timer_reg == TMR_LAST) begin
          viol[TIMEOUT_IDX] = 1'b1;
          timer_next        = timer_reg + TMR_W'(1);
          state_next        = TOUT;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      TOUT: begin
        // Timer frozen; a later drop is not reported again.
        viol[HOLD_IDX] = req & hold_diff;
        if (req && term) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (!req) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign any_viol = |viol;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (capture_en) begin
        adr_reg <= ADR_O;
        dat_reg <= DAT_O;
        sel_reg <= SEL_O;
        we_reg  <= WE_O;
      end
    end
  end

  // A clear coinciding with new violations keeps only the new ones.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      flags_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      flags_reg <= clr_i ? viol : (flags_reg | viol);
      pulse_reg <= any_viol;
    end
  end

  vgm_wb_mon_sat_counter #(.WIDTH(CNT_W)) u_txn_cnt (
    .clk      (CLK_I),
    .rst_n    (RST_N_I),
    .inc      (complete),
    .clr      (clr_i),
    .load_one (clr_i & complete),
    .count    (txn_cnt_o)
  );

  vgm_wb_mon_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk      (CLK_I),
    .rst_n    (RST_N_I),
    .inc      (any_viol),
    .clr      (clr_i),
    .load_one (clr_i & any_viol),
    .count    (err_cnt_o)
  );

  assign busy_o      = (state_reg != IDLE);
  assign err_flags_o = flags_reg;
  assign err_pulse_o = pulse_reg;

`ifdef VGM_WB_MON_ASSERT_EN
  hold_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[HOLD_IDX])
    else $error("HOLD");
  stb_drop_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[STB_DROP_IDX])
    else $error("STB_DROP");
  timeout_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[TIMEOUT_IDX])
    else $error("TIMEOUT");
  multi_term_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[MULTI_TERM_IDX])
    else $error("MULTI_TERM");
  term_idle_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[TERM_IDLE_IDX])
    else $error("TERM_IDLE");
  stb_no_cyc_a: assert property (@(posedge CLK_I) disable iff (!RST_N_I) !viol[STB_NO_CYC_IDX])
    else $error("STB_NO_CYC");
`else
`endif

endmodule

// File: tb/tb_vgm_wb_master_protocol_monitor.sv
// Scoreboard bench for vgm_wb_master_protocol_monitor: directed scenarios then
// random traffic, with expected outputs from a request-level reference model.
module tb_vgm_wb_master_protocol_monitor;

  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TMR_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CMAX    = 15;

  logic             CLK_I = 1'b0;
  logic             RST_N_I;
  logic             CYC_O, STB_O, WE_O;
  logic [ADR_W-1:0] ADR_O;
  logic [DAT_W-1:0] DAT_O;
  logic [SEL_W-1:0] SEL_O;
  logic             ACK_I, ERR_I, RTY_I, clr_i;
  logic             busy_o, err_pulse_o;
  logic [5:0]       err_flags_o;
  logic [CNT_W-1:0] txn_cnt_o, err_cnt_o;

  vgm_wb_master_protocol_monitor #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W), .CNT_W(CNT_W)
  ) dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .RTY_I(RTY_I), .clr_i(clr_i), .busy_o(busy_o), .err_flags_o(err_flags_o),
    .err_pulse_o(err_pulse_o), .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic             busy;
    logic [5:0]       flags;
    logic             pulse;
    logic [CNT_W-1:0] txn;
    logic [CNT_W-1:0] errc;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: a request is "pending" from its unterminated strobe until it ends.
  bit         m_pending, m_timed;
  int         m_age;
  logic [31:0] m_adr, m_dat;
  logic [3:0] m_sel;
  logic       m_we;
  logic [5:0] m_flags;
  int         m_txn, m_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_timed = 0; m_age = 0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 0;
    m_flags = '0; m_txn = 0; m_err = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit req, term, done;
    int nt;
    logic [5:0] v;
    e = '0;
    if (!RST_N_I) begin
      model_reset();
      return;
    end
    req  = CYC_O && STB_O;
    nt   = int'(ACK_I) + int'(ERR_I) + int'(RTY_I);
    term = (nt > 0);
    v    = '0;
    done = 0;
    if (STB_O && !CYC_O) v[5] = 1'b1;
    if (nt > 1)          v[3] = 1'b1;
    if (term && !req)    v[4] = 1'b1;
    if (m_pending && req &&
        (ADR_O != m_adr || WE_O != m_we || SEL_O != m_sel || (m_we && DAT_O != m_dat)))
      v[0] = 1'b1;
    if (req && term) begin
      done = 1;
      m_pending = 0;
    end else if (!m_pending) begin
      if (req) begin
        m_pending = 1; m_timed = 0; m_age = 1;
        m_adr = ADR_O; m_dat = DAT_O; m_sel = SEL_O; m_we = WE_O;
      end
    end else if (!req) begin
      if (!m_timed && !term) v[1] = 1'b1;
      m_pending = 0;
    end else if (!m_timed) begin
      m_age++;
      if (m_age >= TIMEOUT) begin
        v[2] = 1'b1;
        m_timed = 1;
      end
    end
    if (clr_i) begin
      m_flags = v;
      m_err   = (v != 0) ? 1 : 0;
      m_txn   = done ? 1 : 0;
    end else begin
      m_flags = m_flags | v;
      if (v != 0 && m_err < CMAX) m_err++;
      if (done && m_txn < CMAX)   m_txn++;
    end
    e.busy  = m_pending;
    e.flags = m_flags;
    e.pulse = (v != 0);
    e.txn   = CNT_W'(m_txn);
    e.errc  = CNT_W'(m_err);
  endtask

  // Drive one cycle of inputs, predict, and queue the expectation for the monitor.
  task automatic step(input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic ack, input logic err, input logic rty, input logic clr);
    exp_t e;
    CYC_O = cyc; STB_O = stb; WE_O = we; ADR_O = adr; DAT_O = dat; SEL_O = sel;
    ACK_I = ack; ERR_I = err; RTY_I = rty; clr_i = clr;
    model_step(e);
    @(posedge CLK_I);
    sb_q.push_back(e);
    #2;
  endtask

  task automatic idle(input logic clr);
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, clr);
  endtask

  // Monitor: outputs are valid every cycle, compared just after the edge.
  always @(posedge CLK_I) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("busy",  int'(busy_o),      int'(e.busy));
      check("flags", int'(err_flags_o), int'(e.flags));
      check("pulse", int'(err_pulse_o), int'(e.pulse));
      check("txn",   int'(txn_cnt_o),   int'(e.txn));
      check("errc",  int'(err_cnt_o),   int'(e.errc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N_I = 0;
    CYC_O = 0; STB_O = 0; WE_O = 0; ADR_O = '0; DAT_O = '0; SEL_O = '0;
    ACK_I = 0; ERR_I = 0; RTY_I = 0; clr_i = 0;
    model_reset();
    repeat (2) @(posedge CLK_I);
    #2;
    check("rst_busy",  int'(busy_o), 0);
    check("rst_flags", int'(err_flags_o), 0);
    check("rst_txn",   int'(txn_cnt_o), 0);
    check("rst_errc",  int'(err_cnt_o), 0);
    RST_N_I = 1;

    // Single-cycle ack.
    step(1, 1, 0, 32'h100, 32'h0, 4'hF, 1, 0, 0, 0);
    idle(0);
    check("single_txn", int'(txn_cnt_o), 1);

    // Address change mid-request, acked on cycle 3.
    step(1, 1, 1, 32'h200, 32'hAA, 4'hF, 0, 0, 0, 0);
    step(1, 1, 1, 32'h204, 32'hAA, 4'hF, 0, 0, 0, 0);
    step(1, 1, 1, 32'h204, 32'hAA, 4'hF, 1, 0, 0, 0);
    idle(0);
    check("hold_flag", int'(err_flags_o), 1);
    check("hold_txn",  int'(txn_cnt_o), 2);

    // Timeout, then late ack.
    idle(1);
    repeat (14) step(1, 1, 0, 32'h300, 32'h0, 4'h3, 0, 0, 0, 0);
    step(1, 1, 0, 32'h300, 32'h0, 4'h3, 1, 0, 0, 0);
    idle(0);
    check("tout_flags", int'(err_flags_o), 6'b000100);

    // Termination faults.
    idle(1);
    step(1, 1, 0, 32'h400, 32'h0, 4'hF, 1, 1, 0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 0);
    step(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
    idle(0);
    check("fault_flags", int'(err_flags_o), 6'b111000);

    // Strobe drop, then reset mid-WAIT.
    idle(1);
    step(1, 1, 0, 32'h500, 32'h0, 4'hF, 0, 0, 0, 0);
    idle(0);
    check("drop_flags", int'(err_flags_o), 6'b000010);
    step(1, 1, 0, 32'h510, 32'h0, 4'hF, 0, 0, 0, 0);
    step(1, 1, 0, 32'h510, 32'h0, 4'hF, 0, 0, 0, 0);
    RST_N_I = 0;
    #1;
    check("arst_busy",  int'(busy_o), 0);
    check("arst_flags", int'(err_flags_o), 0);
    check("arst_pulse", int'(err_pulse_o), 0);
    check("arst_txn",   int'(txn_cnt_o), 0);
    check("arst_errc",  int'(err_cnt_o), 0);
    step(1, 1, 0, 32'h510, 32'h0, 4'hF, 0, 0, 0, 0);
    step(1, 1, 0, 32'h510, 32'h0, 4'hF, 0, 0, 0, 0);
    RST_N_I = 1;
    idle(0);
    idle(0);
    check("post_rst_flags", int'(err_flags_o), 0);

    // Clear colliding with a HOLD violation.
    step(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h600, 32'h0, 4'hF, 0, 0, 0, 0);
    step(1, 1, 0, 32'h604, 32'h0, 4'hF, 0, 0, 0, 1);
    check("clr_flags", int'(err_flags_o), 6'b000001);
    check("clr_errc",  int'(err_cnt_o), 1);
    step(1, 1, 0, 32'h600, 32'h0, 4'hF, 1, 0, 0, 0);
    idle(0);

    // Error counter saturation.
    repeat (20) step(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
    check("sat_errc", int'(err_cnt_o), CMAX);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic c, s, w, a, er, rt, cl;
      logic [31:0] ad, d;
      logic [3:0] se;
      c = CYC_O; s = STB_O; w = WE_O; ad = ADR_O; d = DAT_O; se = SEL_O;
      if (!m_pending) begin
        r = $urandom_range(0, 99);
        if (r < 50) begin
          c = 1; s = 1; w = 1'($urandom_range(0, 1));
          ad = 32'($urandom_range(0, 15)) << 2;
          d = $urandom; se = 4'($urandom_range(0, 15));
        end else if (r < 55) begin
          c = 0; s = 1;
        end else begin
          c = 1'($urandom_range(0, 1)); s = 0;
        end
      end else begin
        r = $urandom_range(0, 99);
        if (r < 5)       ad = ad ^ 32'h4;
        else if (r < 8)  d  = d ^ 32'h1;
        else if (r < 11) se = se ^ 4'h1;
        else if (r < 13) w  = !w;
        if ($urandom_range(0, 99) < 6) s = 0;
      end
      a  = ($urandom_range(0, 99) < 25);
      er = ($urandom_range(0, 99) < 4);
      rt = ($urandom_range(0, 99) < 4);
      cl = ($urandom_range(0, 99) < 3);
      step(c, s, w, ad, d, se, a, er, rt, cl);
    end

    idle(0);
    idle(0);
    @(posedge CLK_I);
    #2;
    check("queue_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
